trivium_seq_ctrl: RTL and testbench
===================================

Name: trivium_seq_ctrl

Overview:
Sequencing controller for the bit-serial Trivium-lite keystream core. It accepts a seed and loads the core, then runs a discard warm-up. After warm-up it steps the core 8 times per byte and MSB-first packs the keystream bits into a byte. Each keystream byte is XORed with one input byte under valid/ready handshakes, and the core is re-keyed periodically. It sits between the host byte stream and the core, and owns all core control strobes.

Parameters:
WARMUP_CYCLES, 64, core steps discarded after each load (1..1023)
REKEY_BYTES, 0, bytes between automatic re-keys; 0 = never re-key

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous abort, highest priority
cfg_seed_valid  in  1  seed offered
cfg_seed  in  8  seed value
cfg_seed_ready  out  1  seed accepted when valid&ready
core_load  out  1  one-cycle load strobe to core
core_seed  out  8  seed presented with core_load
core_step  out  1  advance core one bit this cycle
core_bit  in  1  core keystream bit, valid in cycles where core_step=1
in_valid  in  1  plaintext/ciphertext byte offered
in_data  in  8  input byte
in_ready  out  1  input byte accepted when valid&ready
out_valid  out  1  result byte available
out_data  out  8  in_data XOR keystream byte
out_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
keyed  out  1  warm-up done since last load

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, all outputs 0 except cfg_seed_ready=1. Internal seed_reg, epoch, ks, bit_cnt, warm_cnt and byte_cnt all reset to 0.
- States: IDLE, LOAD, WARM, GEN, KSRDY.
- IDLE:
  - cfg_seed_ready=1.
  - Seed fire with cfg_seed not 8'h00 and not 8'hFF: latch seed_reg, set epoch=0, go to LOAD.
  - Seed 00 or FF: consumed (ready was high) but ignored; stay in IDLE.
- cfg_seed_ready=0 in every state other than IDLE. Seeds offered outside IDLE are not consumed.
- LOAD:
  - core_load=1 for exactly one cycle, with core_seed = seed_reg XOR epoch.
  - Clear keyed, clear warm_cnt, go to WARM.
- WARM:
  - core_step=1 every cycle for WARMUP_CYCLES cycles; bits are discarded.
  - On the last warm cycle: set keyed=1, go to GEN.
- GEN:
  - core_step=1 for 8 cycles; ks <= {ks[6:0], core_bit}, so the first bit lands in the MSB.
  - On bit_cnt==7: go to KSRDY.
- KSRDY:
  - core_step=0.
  - in_ready = !out_valid | out_ready.
  - On in fire: out_data <= in_data ^ ks, out_valid <= 1, byte_cnt++.
  - Next state after in fire: LOAD with epoch++ if REKEY_BYTES!=0 and byte_cnt+1==REKEY_BYTES (byte_cnt then cleared); otherwise GEN.
- in_ready=0 in all states other than KSRDY, so input is never consumed without a full keystream byte.
- Output register:
  - out_valid is held, and out_data is stable, until out_ready.
  - An out fire in the same cycle as an in fire reloads the register with no bubble.
  - An out fire with no in fire clears out_valid.
  - Draining is allowed in any state.
- Throughput: 1 byte per 9 cycles minimum (8 GEN + 1 KSRDY) with no backpressure.
- Latency: seed fire at cycle 0, core_load at 1, warm cycles 2..W+1, GEN W+2..W+9, in_ready high at W+10.
- epoch: 8-bit wrap-around (FF -> 00).
- abort=1 (any state, including mid-GEN or mid-WARM):
  - Next cycle: IDLE, out_valid=0, keyed=0, byte_cnt=0, core_step=0.
  - Any pending output is dropped.
  - abort takes priority over a simultaneous seed/in/out fire; none of those take effect.
- Reset mid-operation: immediate return to reset values; no core strobes.

Optional Feature:
Macro TRIV_CTRL_BYTECNT_EN.
- Defined: adds port bytes_done out 16, counting in fires. Saturates at 16'hFFFF. Cleared by reset, abort and each new seed accepted in IDLE; not cleared by re-key.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Core model core_bit=1 constant, WARMUP_CYCLES=4: seed 8'h5A -> core_load at cycle 1 with core_seed=5A; in_ready first high at cycle 14; in_data=3C -> out_data=C3.
- Seeds 8'h00 then 8'hFF: core_load never asserts, state stays IDLE. Then seed 8'h01 -> normal load.
- Core model bit pattern 1,0,1,1,0,0,1,0 -> ks=B2; in_data=FF -> out_data=4D. out_ready held 0 for 20 cycles -> out_valid and out_data stable, in_ready=0 after the next ks byte is ready.
- REKEY_BYTES=2, seed 8'h10: after the 2nd in fire, core_load with core_seed=11; after the 4th, core_seed=12; keyed drops during each WARM.
- abort asserted at GEN bit 3 together with an in fire -> next cycle IDLE, out_valid=0, core_step=0; new seed 8'h22 restarts from LOAD.
- rst_n pulsed low mid-WARM -> all outputs at reset values asynchronously; with TRIV_CTRL_BYTECNT_EN, bytes_done reads 0 after 3 bytes then a reset.

Source files
------------

// File: rtl/trivium_seq_ctrl.sv
// Sequencing controller for the bit-serial Trivium-lite core: seed load, warm-up, byte packing, XOR and re-key.
// Optional macro TRIV_CTRL_BYTECNT_EN adds the saturating bytes_done counter port.
module trivium_seq_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned REKEY_BYTES   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic        cfg_seed_valid,
  input  logic [7:0]  cfg_seed,
  output logic        cfg_seed_ready,
  output logic        core_load,
  output logic [7:0]  core_seed,
  output logic        core_step,
  input  logic        core_bit,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
`ifdef TRIV_CTRL_BYTECNT_EN
  output logic [15:0] bytes_done,
`endif
  output logic        keyed
);

  localparam int unsigned WARM_W = 10;
  localparam int unsigned BYTE_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_GEN,
    S_KSRDY
  } state_e;

  state_e              state_q;
  logic [7:0]          seed_q;
  logic [7:0]          epoch_q;
  logic [7:0]          ks_q;
  logic [2:0]          bit_cnt_q;
  logic [WARM_W-1:0]   warm_cnt_q;
  logic [BYTE_W-1:0]   byte_cnt_q;
  logic [7:0]          out_data_q;
  logic                out_valid_q;
  logic                core_load_q;
  logic [7:0]          core_seed_q;
  logic                core_step_q;
  logic                keyed_q;
  logic                seed_rdy_q;
`ifdef TRIV_CTRL_BYTECNT_EN
  logic [CNT_W-1:0]    bytes_done_q;
`endif

  logic       seed_ok_c;
  logic       seed_fire_c;
  logic       in_ready_c;
  logic       in_fire_c;
  logic       out_fire_c;
  logic       rekey_c;
  logic       warm_last_c;
  logic [7:0] epoch_d;

  // Handshake and re-key decode
  always_comb begin
    seed_ok_c   = (cfg_seed != 8'h00) && (cfg_seed != 8'hFF);
    seed_fire_c = cfg_seed_valid && seed_rdy_q;
    in_ready_c  = (state_q == S_KSRDY) && (!out_valid_q || out_ready);
    in_fire_c   = in_valid && in_ready_c;
    out_fire_c  = out_valid_q && out_ready;
    rekey_c     = (REKEY_BYTES != 0) &&
                  ((32'(byte_cnt_q) + 32'd1) == 32'(REKEY_BYTES));
    warm_last_c = (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1));
    epoch_d     = epoch_q + 8'd1;
  end

  // Sequencer: state, strobes, keystream packing and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      seed_q       <= 8'h00;
      epoch_q      <= 8'h00;
      ks_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      warm_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      core_load_q  <= 1'b0;
      core_seed_q  <= 8'h00;
      core_step_q  <= 1'b0;
      keyed_q      <= 1'b0;
      seed_rdy_q   <= 1'b1;
`ifdef TRIV_CTRL_BYTECNT_EN
      bytes_done_q <= '0;
`endif
    end else if (abort) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      core_load_q  <= 1'b0;
      core_step_q  <= 1'b0;
      keyed_q      <= 1'b0;
      byte_cnt_q   <= '0;
      seed_rdy_q   <= 1'b1;
`ifdef TRIV_CTRL_BYTECNT_EN
      bytes_done_q <= '0;
`endif
    end else begin
      core_load_q <= 1'b0;
      if (out_fire_c) out_valid_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // Degenerate all-zero/all-one seeds are swallowed without a load
          if (seed_fire_c && seed_ok_c) begin
            seed_q       <= cfg_seed;
            epoch_q      <= 8'h00;
            core_seed_q  <= cfg_seed;
            core_load_q  <= 1'b1;
            seed_rdy_q   <= 1'b0;
            state_q      <= S_LOAD;
`ifdef TRIV_CTRL_BYTECNT_EN
            bytes_done_q <= '0;
`endif
          end
        end
        S_LOAD: begin
          keyed_q     <= 1'b0;
          warm_cnt_q  <= '0;
          core_step_q <= 1'b1;
          state_q     <= S_WARM;
        end
        S_WARM: begin
          if (warm_last_c) begin
            keyed_q   <= 1'b1;
            bit_cnt_q <= 3'd0;
            state_q   <= S_GEN;
          end else begin
            warm_cnt_q <= warm_cnt_q + WARM_W'(1);
          end
        end
        S_GEN: begin
          ks_q      <= {ks_q[6:0], core_bit};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            core_step_q <= 1'b0;
            state_q     <= S_KSRDY;
          end
        end
        S_KSRDY: begin
          if (in_fire_c) begin
            out_data_q  <= in_data ^ ks_q;
            out_valid_q <= 1'b1;
`ifdef TRIV_CTRL_BYTECNT_EN
            if (bytes_done_q != {CNT_W{1'b1}}) bytes_done_q <= bytes_done_q + CNT_W'(1);
`endif
            if (rekey_c) begin
              byte_cnt_q  <= '0;
              epoch_q     <= epoch_d;
              core_seed_q <= seed_q ^ epoch_d;
              core_load_q <= 1'b1;
              state_q     <= S_LOAD;
            end else begin
              byte_cnt_q  <= byte_cnt_q + BYTE_W'(1);
              bit_cnt_q   <= 3'd0;
              core_step_q <= 1'b1;
              state_q     <= S_GEN;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          seed_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_seed_ready = seed_rdy_q;
  assign core_load      = core_load_q;
  assign core_seed      = core_seed_q;
  assign core_step      = core_step_q;
  assign in_ready       = in_ready_c;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign busy           = (state_q != S_IDLE);
  assign keyed          = keyed_q;
`ifdef TRIV_CTRL_BYTECNT_EN
  assign bytes_done     = bytes_done_q;
`endif

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Directed self-checking bench for trivium_seq_ctrl (WARMUP_CYCLES=4, REKEY_BYTES=2).
module tb_trivium_seq_ctrl;

  localparam int unsigned WARM  = 4;
  localparam int unsigned REKEY = 2;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        cfg_seed_valid;
  logic [7:0]  cfg_seed;
  logic        cfg_seed_ready;
  logic        core_load;
  logic [7:0]  core_seed;
  logic        core_step;
  logic        core_bit;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        keyed;
`ifdef TRIV_CTRL_BYTECNT_EN
  logic [15:0] bytes_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Core model: replays pat MSB-first across keystream steps
  logic [7:0]  pat = 8'hFF;
  int unsigned gen_cnt = 0;
  int unsigned base = 0;
  logic [2:0]  pidx;

  trivium_seq_ctrl #(.WARMUP_CYCLES(WARM), .REKEY_BYTES(REKEY)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .cfg_seed_valid(cfg_seed_valid), .cfg_seed(cfg_seed), .cfg_seed_ready(cfg_seed_ready),
    .core_load(core_load), .core_seed(core_seed), .core_step(core_step), .core_bit(core_bit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy),
`ifdef TRIV_CTRL_BYTECNT_EN
    .bytes_done(bytes_done),
`endif
    .keyed(keyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (core_step && keyed) gen_cnt <= gen_cnt + 1;
  assign pidx     = 3'(gen_cnt - base);
  assign core_bit = pat[3'd7 - pidx];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort;
    in_valid       = 1'b0;
    cfg_seed_valid = 1'b0;
    abort          = 1'b1;
    tick();
    abort          = 1'b0;
  endtask

  task automatic send_seed(input logic [7:0] s);
    cfg_seed       = s;
    cfg_seed_valid = 1'b1;
    tick();
    cfg_seed_valid = 1'b0;
  endtask

  task automatic wait_in_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({cfg_seed_ready, core_load, core_step, in_ready, out_valid, busy, keyed, out_data, core_seed}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b ld=%b st=%b ir=%b ov=%b busy=%b keyed=%b od=%h cs=%h, expected rdy=1 rest 0",
               cfg_seed_ready, core_load, core_step, in_ready, out_valid, busy, keyed, out_data, core_seed);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    pat = 8'hFF;
    base = gen_cnt;
    out_ready = 1'b1;
    cfg_seed = 8'h5A;
    cfg_seed_valid = 1'b1;
    n_checks++;
    if (cfg_seed_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_seed_ready: got %b expected 1", cfg_seed_ready);
    end
    tick();
    cfg_seed = 8'h77;
    n_checks++;
    if ({core_load, core_seed} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL basic_load: got load=%b seed=%h expected load=1 seed=5a", core_load, core_seed);
    end
    for (int c = 2; c <= 14; c++) begin
      tick();
      if (c < 14) begin
        n_checks++;
        if ({in_ready, cfg_seed_ready} !== 2'b00) begin
          n_fail++; $display("FAIL basic_not_ready_c%0d: got in_ready=%b seed_ready=%b expected 0 0", c, in_ready, cfg_seed_ready);
        end
      end
    end
    cfg_seed_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready_c14: got %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hC3}) begin
      n_fail++; $display("FAIL basic_out: got valid=%b data=%h expected 1 c3", out_valid, out_data);
    end
    do_abort();
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL basic_abort_idle: got busy=%b ov=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_bad_seeds;
    logic [7:0] bad [2];
    bad[0] = 8'h00;
    bad[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      cfg_seed = bad[i];
      cfg_seed_valid = 1'b1;
      n_checks++;
      if (cfg_seed_ready !== 1'b1) begin
        n_fail++; $display("FAIL bad_seed_ready_%h: got %b expected 1", bad[i], cfg_seed_ready);
      end
      tick();
      cfg_seed_valid = 1'b0;
      n_checks++;
      if ({core_load, busy} !== 2'b00) begin
        n_fail++; $display("FAIL bad_seed_ignored_%h: got load=%b busy=%b expected 0 0", bad[i], core_load, busy);
      end
    end
    repeat (3) tick();
    n_checks++;
    if ({core_load, busy, cfg_seed_ready} !== 3'b001) begin
      n_fail++; $display("FAIL bad_seed_idle: got load=%b busy=%b rdy=%b expected 0 0 1", core_load, busy, cfg_seed_ready);
    end
    send_seed(8'h01);
    n_checks++;
    if ({core_load, core_seed, busy} !== {1'b1, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL good_seed_load: got load=%b seed=%h busy=%b expected 1 01 1", core_load, core_seed, busy);
    end
    do_abort();
  endtask

  task automatic test_stall;
    bit ok;
    pat = 8'hB2;
    base = gen_cnt;
    out_ready = 1'b1;
    send_seed(8'h5B);
    wait_in_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL stall_wait_ready: got timeout expected in_ready");
    end
    in_valid = 1'b1;
    in_data  = 8'hFF;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h4D}) begin
      n_fail++; $display("FAIL stall_first_out: got valid=%b data=%h expected 1 4d", out_valid, out_data);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'h4D, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold_c%0d: got valid=%b data=%h in_ready=%b expected 1 4d 0", c, out_valid, out_data, in_ready);
      end
    end
    n_checks++;
    if ({core_step, busy} !== 2'b01) begin
      n_fail++; $display("FAIL stall_ksrdy_hold: got step=%b busy=%b expected 0 1", core_step, busy);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hB2}) begin
      n_fail++; $display("FAIL stall_reload_out: got valid=%b data=%h expected 1 b2", out_valid, out_data);
    end
    n_checks++;
    if ({core_load, core_seed} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL stall_rekey_load: got load=%b seed=%h expected 1 5a", core_load, core_seed);
    end
    do_abort();
  endtask

  task automatic test_rekey;
    logic [7:0] seeds [3];
    int         fires_at [3];
    int         nl;
    int         fires;
    bit         prev_load;
    nl = 0;
    fires = 0;
    prev_load = 1'b0;
    pat = 8'hFF;
    base = gen_cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    send_seed(8'h10);
    for (int c = 0; c < 200; c++) begin
      if (prev_load) begin
        n_checks++;
        if (keyed !== 1'b0) begin
          n_fail++; $display("FAIL rekey_keyed_warm_%0d: got %b expected 0", nl, keyed);
        end
      end
      prev_load = core_load;
      if (core_load) begin
        seeds[nl]    = core_seed;
        fires_at[nl] = fires;
        nl++;
        if (nl == 3) break;
      end
      if (in_valid && in_ready) fires++;
      tick();
    end
    n_checks++;
    if (nl !== 3) begin
      n_fail++; $display("FAIL rekey_load_count: got %0d expected 3", nl);
    end else begin
      n_checks++;
      if ({seeds[0], seeds[1], seeds[2]} !== {8'h10, 8'h11, 8'h12}) begin
        n_fail++; $display("FAIL rekey_seeds: got %h %h %h expected 10 11 12", seeds[0], seeds[1], seeds[2]);
      end
      n_checks++;
      if ((fires_at[0] != 0) || (fires_at[1] != 2) || (fires_at[2] != 4)) begin
        n_fail++; $display("FAIL rekey_fire_points: got %0d %0d %0d expected 0 2 4", fires_at[0], fires_at[1], fires_at[2]);
      end
    end
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL rekey_out: got valid=%b data=%h expected 1 ff", out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (keyed !== 1'b0) begin
      n_fail++; $display("FAIL rekey_keyed_warm_last: got %b expected 0", keyed);
    end
    do_abort();
  endtask

  task automatic test_abort;
    bit ok;
    pat = 8'hFF;
    base = gen_cnt;
    out_ready = 1'b0;
    send_seed(8'h33);
    wait_in_ready(ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_wait_ready: got timeout expected in_ready");
    end
    in_valid = 1'b1;
    in_data  = 8'h11;
    repeat (4) tick();
    n_checks++;
    if ({core_step, out_valid} !== 2'b11) begin
      n_fail++; $display("FAIL abort_gen_bit3: got step=%b ov=%b expected 1 1", core_step, out_valid);
    end
    abort = 1'b1;
    out_ready = 1'b1;
    cfg_seed = 8'h22;
    cfg_seed_valid = 1'b1;
    tick();
    abort = 1'b0;
    cfg_seed_valid = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({busy, out_valid, core_step, keyed, core_load, cfg_seed_ready} !== 6'b000001) begin
      n_fail++; $display("FAIL abort_state: got busy=%b ov=%b st=%b keyed=%b ld=%b rdy=%b expected 0 0 0 0 0 1",
                         busy, out_valid, core_step, keyed, core_load, cfg_seed_ready);
    end
    send_seed(8'h22);
    n_checks++;
    if ({core_load, core_seed} !== {1'b1, 8'h22}) begin
      n_fail++; $display("FAIL abort_restart_load: got load=%b seed=%h expected 1 22", core_load, core_seed);
    end
    do_abort();
  endtask

  task automatic test_reset_mid;
`ifdef TRIV_CTRL_BYTECNT_EN
    int fires;
    fires = 0;
    pat = 8'hFF;
    out_ready = 1'b1;
    send_seed(8'h66);
    in_valid = 1'b1;
    in_data  = 8'h00;
    for (int c = 0; c < 200; c++) begin
      if (in_valid && in_ready) fires++;
      tick();
      if (fires == 3) break;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bytes_done !== 16'd3) begin
      n_fail++; $display("FAIL bytecnt_three: got %0d expected 3", bytes_done);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bytes_done !== 16'd0) begin
      n_fail++; $display("FAIL bytecnt_reset: got %0d expected 0", bytes_done);
    end
    #2;
    rst_n = 1'b1;
    tick();
`endif
    pat = 8'hFF;
    out_ready = 1'b1;
    send_seed(8'h44);
    repeat (2) tick();
    n_checks++;
    if ({core_step, keyed, busy} !== 3'b101) begin
      n_fail++; $display("FAIL midwarm_state: got step=%b keyed=%b busy=%b expected 1 0 1", core_step, keyed, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cfg_seed_ready, core_load, core_step, in_ready, out_valid, busy, keyed, out_data, core_seed}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL midwarm_async_reset: got rdy=%b ld=%b st=%b ir=%b ov=%b busy=%b keyed=%b od=%h cs=%h expected rdy=1 rest 0",
                         cfg_seed_ready, core_load, core_step, in_ready, out_valid, busy, keyed, out_data, core_seed);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({busy, core_step, core_load, cfg_seed_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL postreset_idle: got busy=%b st=%b ld=%b rdy=%b expected 0 0 0 1", busy, core_step, core_load, cfg_seed_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    cfg_seed_valid = 1'b0;
    cfg_seed = 8'h00;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_bad_seeds();
    test_stall();
    test_rekey();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
